// File: rtl/fb_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rd_pkg
//  Description : Shared types, burst geometry and address packing for the
//                512-bit frame buffer read master.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_rd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        NEXT  = 3'd3,
        DRAIN = 3'd4
    } rd_state_e;

    localparam int AXI_AW      = 32;
    localparam int AXI_DW      = 512;
    localparam int BURST_LEN   = 32;
    localparam int BEAT_BYTES  = 64;
    localparam int BEAT_SHIFT  = 6;
    localparam int BURST_SHIFT = 11;

    // Same layout as the writer: frame slot, line index, burst within line.
    function automatic logic [AXI_AW-1:0] pack_rd_addr(
        input logic [2:0]  frame,
        input logic [11:0] y,
        input logic [0:0]  burst_idx
    );
        return {5'b0, frame, y, burst_idx, 11'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_address_decoder_512_if.sv
`default_nettype none
// ============================================================================
//  Module      : rd_address_decoder_512_if
//  Description : AXI4 read channel (AR/R) plus 512-bit pixel stream bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface rd_address_decoder_512_if;
    import fb_rd_pkg::*;

    logic                out_rd_avalid;
    logic                in_rd_aready;
    logic [AXI_AW-1:0]   out_rd_addr;
    logic                in_rd_valid;
    logic                in_rd_last;
    logic [AXI_DW-1:0]   in_rd_data;
    logic                out_rd_ready;
    logic                out_pix_valid;
    logic                in_pix_ready;
    logic [AXI_DW-1:0]   out_pix_data;
    logic                out_pix_last;

    // Read master side (the decoder itself)
    modport master (
        output out_rd_avalid, out_rd_addr, out_rd_ready,
               out_pix_valid, out_pix_data, out_pix_last,
        input  in_rd_aready, in_rd_valid, in_rd_last, in_rd_data, in_pix_ready
    );

    // Memory / pixel sink side
    modport slave (
        input  out_rd_avalid, out_rd_addr, out_rd_ready,
               out_pix_valid, out_pix_data, out_pix_last,
        output in_rd_aready, in_rd_valid, in_rd_last, in_rd_data, in_pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/rd_line_fifo_512.sv
`default_nettype none
// ============================================================================
//  Module      : rd_line_fifo_512
//  Description : Synchronous first-word-fall-through FIFO with occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_line_fifo_512 #(
    parameter int AW = 6,
    parameter int DW = 512
) (
    input  wire           clk,
    input  wire           rst,
    input  wire           wr_en,
    input  wire  [DW-1:0] wr_data,
    input  wire           rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          w_wr;
    logic          w_rd;

    assign w_rd = rd_en && (count_q != '0);
    assign w_wr = wr_en && (count_q != (AW+1)'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/rd_address_decoder_512.sv
`default_nettype none
// ============================================================================
//  Module      : rd_address_decoder_512
//  Description : AXI4 read master fetching one video line per request in
//                32-beat bursts and streaming it out as 512-bit pixel beats.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_address_decoder_512
    import fb_rd_pkg::*;
#(
    parameter int X_WID   = 12,
    parameter int Y_WID   = 12,
    parameter int FIFO_AW = 6
) (
    input  wire                       axi_clk,
    input  wire                       rst,
    input  wire  [X_WID-1:0]          x_win,
    input  wire                       in_line_start,
    input  wire  [Y_WID-1:0]          in_y,
    input  wire  [2:0]                in_frame_cnt,
    output logic                      out_busy,
    output logic                      out_line_done,
    rd_address_decoder_512_if.master  bus
);
    localparam int XW1 = X_WID + 1;
    localparam int BW  = X_WID - 11;
    localparam int CW  = FIFO_AW + 1;

    rd_state_e          state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pix_done_q, pix_done_d;
    logic [Y_WID-1:0]   y_q, y_d;
    logic [2:0]         frame_q, frame_d;
    logic [BW-1:0]      burst_idx_q, burst_idx_d;
    logic [XW1-1:0]     beat_cnt_q, beat_cnt_d;
    logic [XW1-1:0]     out_idx_q, out_idx_d;

    logic [XW1-1:0]     w_nbeats;
    logic [XW1-1:0]     w_nbursts;
    logic               w_last_burst;
    logic               w_avalid;
    logic               w_rready;
    logic               w_r_hs;
    logic               w_fifo_wr;
    logic               w_pix_hs;
    logic               w_pix_last;
    logic               w_last_hs;
    logic               w_r_fin;
    logic [AXI_DW-1:0]  w_fifo_data;
    logic               w_fifo_valid;
    logic [CW-1:0]      w_fifo_count;

    assign w_nbeats     = ({1'b0, x_win} + XW1'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
    assign w_nbursts    = ({1'b0, x_win} + XW1'((1 << BURST_SHIFT) - 1)) >> BURST_SHIFT;
    assign w_last_burst = (XW1'(burst_idx_q) + XW1'(1)) >= w_nbursts;

    // Only request a burst when the FIFO can absorb all of it, so R never stalls.
    assign w_avalid   = (state_q == ADDR) &&
                        (w_fifo_count <= CW'((1 << FIFO_AW) - BURST_LEN));
    assign w_rready   = (state_q == DATA);
    assign w_r_hs     = w_rready && bus.in_rd_valid;
    assign w_fifo_wr  = w_r_hs && (beat_cnt_q < w_nbeats);
    assign w_pix_hs   = w_fifo_valid && bus.in_pix_ready;
    assign w_pix_last = (out_idx_q + XW1'(1)) == w_nbeats;
    assign w_last_hs  = w_pix_hs && w_pix_last;

    // No further R beats can arrive for this line once this holds.
    assign w_r_fin = (state_q == DRAIN) ||
                     ((state_q == NEXT) && w_last_burst) ||
                     ((state_q == DATA) && w_last_burst && w_r_hs && bus.in_rd_last);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_done_d  = pix_done_q;
        y_d         = y_q;
        frame_d     = frame_q;
        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        out_idx_d   = out_idx_q;

        if (w_r_hs) begin
            beat_cnt_d = beat_cnt_q + XW1'(1);
        end
        if (w_pix_hs) begin
            out_idx_d = out_idx_q + XW1'(1);
        end
        if (w_last_hs) begin
            pix_done_d = 1'b1;
        end
        if (busy_q && !done_q && w_r_fin && (w_last_hs || pix_done_q)) begin
            done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_line_start && !busy_q) begin
                    busy_d      = 1'b1;
                    y_d         = in_y;
                    frame_d     = in_frame_cnt;
                    burst_idx_d = '0;
                    beat_cnt_d  = '0;
                    out_idx_d   = '0;
                    pix_done_d  = 1'b0;
                    if (w_nbursts == '0) begin
                        done_d  = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (w_avalid && bus.in_rd_aready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_r_hs && bus.in_rd_last) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (w_last_burst) begin
                    state_d = DRAIN;
                end else begin
                    burst_idx_d = burst_idx_q + BW'(1);
                    state_d     = ADDR;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The done pulse is only raised once R is finished, so the line can end from any state.
        if (done_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_done_q  <= 1'b0;
            y_q         <= '0;
            frame_q     <= '0;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_done_q  <= pix_done_d;
            y_q         <= y_d;
            frame_q     <= frame_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            out_idx_q   <= out_idx_d;
        end
    end

    rd_line_fifo_512 #(
        .AW (FIFO_AW),
        .DW (AXI_DW)
    ) u_fifo (
        .clk     (axi_clk),
        .rst     (rst),
        .wr_en   (w_fifo_wr),
        .wr_data (bus.in_rd_data),
        .rd_en   (w_pix_hs),
        .rd_data (w_fifo_data),
        .rd_valid(w_fifo_valid),
        .count   (w_fifo_count)
    );

    assign bus.out_rd_avalid = w_avalid;
    assign bus.out_rd_addr   = pack_rd_addr(frame_q, y_q, burst_idx_q);
    assign bus.out_rd_ready  = w_rready;
    assign bus.out_pix_valid = w_fifo_valid;
    // Uninitialised storage must not leak onto the bus when the FIFO is empty.
    assign bus.out_pix_data  = w_fifo_valid ? w_fifo_data : '0;
    assign bus.out_pix_last  = w_fifo_valid && w_pix_last;
    assign out_busy          = busy_q;
    assign out_line_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_address_decoder_512.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rd_address_decoder_512
//  Description : Directed line-fetch vectors against a behavioural AXI slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rd_address_decoder_512;
    import fb_rd_pkg::*;

    logic        axi_clk = 1'b0;
    logic        rst;
    logic [11:0] x_win;
    logic        in_line_start;
    logic [11:0] in_y;
    logic [2:0]  in_frame_cnt;
    logic        out_busy;
    logic        out_line_done;

    always #5 axi_clk = ~axi_clk;

    rd_address_decoder_512_if bus ();

    rd_address_decoder_512 #(.X_WID(12), .Y_WID(12), .FIFO_AW(6)) dut (
        .axi_clk      (axi_clk),
        .rst          (rst),
        .x_win        (x_win),
        .in_line_start(in_line_start),
        .in_y         (in_y),
        .in_frame_cnt (in_frame_cnt),
        .out_busy     (out_busy),
        .out_line_done(out_line_done),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;

    // Slave model knobs and logs
    int           ar_delay = 0;
    bit           pix_ready_en = 1'b1;
    int           ar_cnt, ar_wait, ar_wait_seen, done_cnt, stab_viol;
    logic [31:0]  ar_addr [4];
    bit           r_active;
    int           r_beat;
    logic [31:0]  r_addr;
    logic [511:0] got_data [$];
    bit           got_last [$];
    logic         prev_av, prev_ar, prev_pv, prev_pr, prev_pl;
    logic [31:0]  prev_addr;
    logic [511:0] prev_pd;

    always @(negedge axi_clk) begin
        if (rst) begin
            r_active = 1'b0; ar_wait = 0;
            bus.in_rd_aready = 1'b0; bus.in_rd_valid = 1'b0; bus.in_rd_last = 1'b0;
            bus.in_rd_data = '0; bus.in_pix_ready = 1'b0;
            prev_av = 1'b0; prev_ar = 1'b0; prev_pv = 1'b0; prev_pr = 1'b0;
        end else begin
            if (prev_av && !prev_ar && (!bus.out_rd_avalid || bus.out_rd_addr != prev_addr))
                stab_viol++;
            if (prev_pv && !prev_pr && (!bus.out_pix_valid || bus.out_pix_data != prev_pd ||
                                        bus.out_pix_last != prev_pl))
                stab_viol++;
            if (out_line_done) done_cnt++;
            // R channel: tag each beat with its burst address and beat index
            if (r_active) begin
                bus.in_rd_valid = 1'b1;
                bus.in_rd_data  = {448'b0, 32'(r_beat), r_addr};
                bus.in_rd_last  = (r_beat == 31);
                if (bus.out_rd_ready) begin
                    r_beat++;
                    if (r_beat == 32) r_active = 1'b0;
                end
            end else begin
                bus.in_rd_valid = 1'b0;
                bus.in_rd_last  = 1'b0;
            end
            if (bus.out_rd_avalid) begin
                bus.in_rd_aready = (ar_wait >= ar_delay);
                if (bus.in_rd_aready) begin
                    if (ar_cnt < 4) ar_addr[ar_cnt] = bus.out_rd_addr;
                    ar_cnt++;
                    ar_wait_seen = ar_wait;
                    ar_wait  = 0;
                    r_active = 1'b1;
                    r_beat   = 0;
                    r_addr   = bus.out_rd_addr;
                end else begin
                    ar_wait++;
                end
            end else begin
                bus.in_rd_aready = 1'b0;
            end
            bus.in_pix_ready = pix_ready_en;
            if (bus.out_pix_valid && bus.in_pix_ready) begin
                got_data.push_back(bus.out_pix_data);
                got_last.push_back(bus.out_pix_last);
            end
            prev_av = bus.out_rd_avalid; prev_ar = bus.in_rd_aready; prev_addr = bus.out_rd_addr;
            prev_pv = bus.out_pix_valid; prev_pr = bus.in_pix_ready;
            prev_pd = bus.out_pix_data;  prev_pl = bus.out_pix_last;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        ar_cnt = 0; done_cnt = 0; stab_viol = 0; ar_wait_seen = -1;
        for (int i = 0; i < 4; i++) ar_addr[i] = '0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic pulse_start(input logic [11:0] xw, input logic [11:0] y, input logic [2:0] fr);
        @(negedge axi_clk);
        x_win = xw; in_y = y; in_frame_cnt = fr; in_line_start = 1'b1;
        @(negedge axi_clk);
        in_line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (out_busy && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        check("idle_within_budget", 64'(n < budget), 64'd1);
        repeat (3) @(negedge axi_clk);
    endtask

    task automatic check_beats(input int nbeats, input logic [31:0] a0, input logic [31:0] a1);
        int bad = 0;
        check("beat_count", 64'(got_data.size()), 64'(nbeats));
        for (int k = 0; k < got_data.size(); k++) begin
            logic [31:0] ea;
            ea = (k < 32) ? a0 : a1;
            if (got_data[k][31:0] != ea || got_data[k][63:32] != 32'(k % 32) ||
                got_data[k][511:64] != '0 || got_last[k] != (k == nbeats - 1))
                bad++;
        end
        check("beat_order_last", 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [11:0] xw;
        logic [11:0] y;
        logic [2:0]  fr;
        int          ars;
        logic [31:0] a0;
        logic [31:0] a1;
        int          beats;
    } vec_t;

    task automatic run_vec(input vec_t v);
        clear_logs();
        pulse_start(v.xw, v.y, v.fr);
        check("busy_after_accept", 64'(out_busy), 64'd1);
        check("avalid_after_accept", 64'(bus.out_rd_avalid), 64'd1);
        wait_idle(3000);
        check("ar_count", 64'(ar_cnt), 64'(v.ars));
        check("ar_addr0", 64'(ar_addr[0]), 64'(v.a0));
        if (v.ars > 1) check("ar_addr1", 64'(ar_addr[1]), 64'(v.a1));
        check_beats(v.beats, v.a0, v.a1);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("handshake_stability", 64'(stab_viol), 64'd0);
        check("busy_low_after", 64'(out_busy), 64'd0);
    endtask

    vec_t vecs [7];

    initial begin
        int n;
        vecs[0] = '{12'd1920, 12'd5,    3'd2, 1, 32'h0200_5000, 32'h0,          30};
        vecs[1] = '{12'd4032, 12'd0,    3'd0, 2, 32'h0000_0000, 32'h0000_0800,  63};
        vecs[2] = '{12'd64,   12'd4095, 3'd7, 1, 32'h07FF_F000, 32'h0,           1};
        vecs[3] = '{12'd2048, 12'd1,    3'd1, 1, 32'h0100_1000, 32'h0,          32};
        vecs[4] = '{12'd2049, 12'd2,    3'd3, 2, 32'h0300_2000, 32'h0300_2800,  33};
        vecs[5] = '{12'd4095, 12'd3,    3'd4, 2, 32'h0400_3000, 32'h0400_3800,  64};
        vecs[6] = '{12'd1,    12'd0,    3'd0, 1, 32'h0000_0000, 32'h0,           1};

        rst = 1'b1; x_win = '0; in_line_start = 1'b0; in_y = '0; in_frame_cnt = '0;
        clear_logs();
        repeat (3) @(negedge axi_clk);
        rst = 1'b0;
        @(negedge axi_clk);
        check("reset_busy", 64'(out_busy), 64'd0);
        check("reset_done", 64'(out_line_done), 64'd0);
        check("reset_avalid", 64'(bus.out_rd_avalid), 64'd0);
        check("reset_addr", 64'(bus.out_rd_addr), 64'd0);
        check("reset_rready", 64'(bus.out_rd_ready), 64'd0);
        check("reset_pix_valid", 64'(bus.out_pix_valid), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Output stalled: both bursts land in the FIFO, nothing more is requested
        clear_logs();
        pix_ready_en = 1'b0;
        pulse_start(12'd4032, 12'd0, 3'd0);
        repeat (150) @(negedge axi_clk);
        check("bp_ar_count", 64'(ar_cnt), 64'd2);
        check("bp_fifo_count", 64'(dut.u_fifo.count_q), 64'd63);
        check("bp_pix_valid", 64'(bus.out_pix_valid), 64'd1);
        check("bp_busy", 64'(out_busy), 64'd1);
        pix_ready_en = 1'b1;
        wait_idle(3000);
        check_beats(63, 32'h0, 32'h800);
        check("bp_done", 64'(done_cnt), 64'd1);
        check("bp_stability", 64'(stab_viol), 64'd0);

        // Slow AR acceptance
        clear_logs();
        ar_delay = 5;
        pulse_start(12'd1920, 12'd5, 3'd2);
        wait_idle(3000);
        ar_delay = 0;
        check("slow_ar_count", 64'(ar_cnt), 64'd1);
        check("slow_ar_wait", 64'(ar_wait_seen), 64'd5);
        check("slow_ar_stability", 64'(stab_viol), 64'd0);
        check("slow_ar_addr", 64'(ar_addr[0]), 64'h0200_5000);
        check_beats(30, 32'h0200_5000, 32'h0);

        // Starts while busy, including on the done cycle, are ignored
        clear_logs();
        pulse_start(12'd1920, 12'd7, 3'd1);
        repeat (10) @(negedge axi_clk);
        in_y = 12'd9; in_line_start = 1'b1;
        @(negedge axi_clk);
        in_line_start = 1'b0;
        n = 0;
        while (!out_line_done && n < 3000) begin
            @(negedge axi_clk);
            n++;
        end
        check("busy_done_seen", 64'(n < 3000), 64'd1);
        in_line_start = 1'b1;
        @(negedge axi_clk);
        in_line_start = 1'b0;
        check("busy_clear_after_done", 64'(out_busy), 64'd0);
        repeat (10) @(negedge axi_clk);
        check("busy_ignore_ar_count", 64'(ar_cnt), 64'd1);
        check("busy_ignore_addr", 64'(ar_addr[0]), 64'h0100_7000);
        check("busy_ignore_still_idle", 64'(out_busy), 64'd0);
        check("busy_ignore_done", 64'(done_cnt), 64'd1);
        check_beats(30, 32'h0100_7000, 32'h0);

        // Zero-width line
        clear_logs();
        pulse_start(12'd0, 12'd3, 3'd1);
        check("zero_busy", 64'(out_busy), 64'd1);
        check("zero_done", 64'(out_line_done), 64'd1);
        check("zero_avalid", 64'(bus.out_rd_avalid), 64'd0);
        @(negedge axi_clk);
        check("zero_busy_after", 64'(out_busy), 64'd0);
        check("zero_done_after", 64'(out_line_done), 64'd0);
        repeat (5) @(negedge axi_clk);
        check("zero_ar_count", 64'(ar_cnt), 64'd0);
        check("zero_beats", 64'(got_data.size()), 64'd0);

        // Reset in the middle of a burst
        clear_logs();
        pulse_start(12'd4032, 12'd1, 3'd1);
        n = 0;
        while (!bus.out_rd_ready && n < 200) begin
            @(negedge axi_clk);
            n++;
        end
        check("mid_rready_seen", 64'(n < 200), 64'd1);
        repeat (5) @(negedge axi_clk);
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_rready", 64'(bus.out_rd_ready), 64'd0);
        check("rst_pix_valid", 64'(bus.out_pix_valid), 64'd0);
        check("rst_pix_data", bus.out_pix_data[63:0], 64'd0);
        check("rst_avalid", 64'(bus.out_rd_avalid), 64'd0);
        check("rst_addr", 64'(bus.out_rd_addr), 64'd0);
        repeat (3) @(negedge axi_clk);
        rst = 1'b0;
        repeat (2) @(negedge axi_clk);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
